// File: rtl/trivium_pkg.sv
// trivium_pkg: shared FSM type, tap positions, register lengths and key/iv load helper for the Trivium stream cipher.
package trivium_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN} state_e;
  localparam int T66 = 66, T69 = 69, T91 = 91, T92 = 92, T93 = 93;
  localparam int T162 = 162, T171 = 171, T175 = 175, T176 = 176, T177 = 177;
  localparam int T243 = 243, T264 = 264, T286 = 286, T287 = 287, T288 = 288;
  localparam int LEN_A = 93, LEN_B = 84, LEN_C = 111;
  localparam int WARMUP_DEF = 1152;
  // bit n-1 of the 288-bit vector holds s_n
  function automatic logic [287:0] load_state(input logic [79:0] key, input logic [79:0] iv);
    return {3'b111, 112'b0, iv, 13'b0, key};
  endfunction
endpackage

// File: rtl/trivium_round.sv
// trivium_round: one combinational Trivium round; bit n-1 of the vector holds s_n.
module trivium_round
  import trivium_pkg::*;
(
  input  logic [287:0] s_i,
  output logic [287:0] s_o,
  output logic         z_o
);
  localparam int B0 = LEN_A;
  localparam int C0 = LEN_A + LEN_B;
  logic t1, t2, t3;
  always_comb begin
    t1 = s_i[T66-1] ^ s_i[T93-1];
    t2 = s_i[T162-1] ^ s_i[T177-1];
    t3 = s_i[T243-1] ^ s_i[T288-1];
    z_o = t1 ^ t2 ^ t3;
    s_o = {s_i[C0+LEN_C-2:C0], t2 ^ (s_i[T175-1] & s_i[T176-1]) ^ s_i[T264-1],
           s_i[B0+LEN_B-2:B0], t1 ^ (s_i[T91-1] & s_i[T92-1]) ^ s_i[T171-1],
           s_i[LEN_A-2:0], t3 ^ (s_i[T286-1] & s_i[T287-1]) ^ s_i[T69-1]};
  end
endmodule

// File: rtl/trivium_stream.sv
// trivium_stream: Trivium keystream generator that XORs W keystream bits onto each accepted plaintext word.
module trivium_stream
  import trivium_pkg::*;
#(
  parameter int W      = 8,
  parameter int WARMUP = WARMUP_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic [79:0]  key,
  input  logic [79:0]  iv,
  output logic         busy,
  output logic         keyed,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  localparam int CYC = WARMUP / W;
  localparam int CW = $clog2(CYC + 1);
  state_e state_q, state_d;
  logic [287:0] s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [287:0] st [W+1];
  logic [W-1:0] z;
  logic fire, last;
  assign st[0] = s_q;
  for (genvar i = 0; i < W; i++) begin : g_round
    trivium_round u_round (.s_i(st[i]), .s_o(st[i+1]), .z_o(z[i]));
  end
  assign busy = state_q == ST_WARMUP;
  assign keyed = state_q == ST_RUN;
  assign in_ready = keyed && (!out_valid_q || out_ready);
  assign fire = in_valid && in_ready;
  assign last = cnt_q == CW'(CYC - 1);
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  // init wins over everything, including a handshake in the same cycle
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    cnt_d = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    if (init) begin
      state_d = ST_WARMUP;
      s_d = load_state(key, iv);
      cnt_d = '0;
      out_valid_d = 1'b0;
    end else if (busy) begin
      s_d = st[W];
      cnt_d = last ? cnt_q : cnt_q + CW'(1);
      state_d = last ? ST_RUN : ST_WARMUP;
    end else if (fire) begin
      s_d = st[W];
      out_data_d = in_data ^ z;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      s_q <= '0;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      cnt_q <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
endmodule

// File: tb/tb_trivium_stream.sv
// tb_trivium_stream: randomized bench for trivium_stream against a bit-serial keystream model; also cross-checks W=1 and W=64.
module tb_trivium_stream;
  logic clk = 0, rst = 1, aux_rst = 1, init = 0, aux_en = 1;
  logic in_valid = 0, out_ready = 0;
  logic [79:0] key = '0, iv = '0;
  logic [7:0] in_data = '0;
  logic busy, keyed, in_ready, out_valid;
  logic [7:0] out_data;
  logic b1, k1, r1, v1, b64, k64, r64, v64;
  logic [0:0] d1;
  logic [63:0] d64;
  int total = 0, bad = 0;
  int m_mode = 0, m_cnt = 0, m_ptr = 0;
  logic m_valid = 0;
  logic [7:0] m_data = '0;
  bit ks [8192];
  bit ks0 [512];
  int a1 = 0, a64 = 0;

  trivium_stream #(.W(8)) dut (
    .clk(clk), .rst(rst), .init(init), .key(key), .iv(iv), .busy(busy), .keyed(keyed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));
  trivium_stream #(.W(1)) u_w1 (
    .clk(clk), .rst(aux_rst), .init(init && aux_en), .key(80'h0), .iv(80'h0), .busy(b1), .keyed(k1),
    .in_valid(1'b1), .in_ready(r1), .in_data(1'b0),
    .out_valid(v1), .out_ready(1'b1), .out_data(d1));
  trivium_stream #(.W(64)) u_w64 (
    .clk(clk), .rst(aux_rst), .init(init && aux_en), .key(80'h0), .iv(80'h0), .busy(b64), .keyed(k64),
    .in_valid(1'b1), .in_ready(r64), .in_data(64'h0),
    .out_valid(v64), .out_ready(1'b1), .out_data(d64));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // bit-serial reference: s[1..288] as in the cipher description, whole-array shift then inject
  task automatic gen(input logic [79:0] k, input logic [79:0] v, input int warm, input int n);
    bit s [1:288];
    bit t1, t2, t3, zz;
    for (int i = 1; i <= 288; i++) s[i] = 0;
    for (int i = 0; i < 80; i++) begin
      s[i+1] = k[i];
      s[i+94] = v[i];
    end
    s[286] = 1; s[287] = 1; s[288] = 1;
    for (int r = 0; r < warm + n; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      zz = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 1; i--) s[i] = s[i-1];
      s[1] = t3; s[94] = t1; s[178] = t2;
      if (r >= warm) ks[r-warm] = zz;
    end
  endtask

  function automatic logic [7:0] ksw(input int p);
    for (int j = 0; j < 8; j++) ksw[j] = ks[p+j];
  endfunction

  function automatic logic [63:0] ks0w(input int n);
    for (int j = 0; j < 64; j++) ks0w[j] = ks0[n*64+j];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_cnt = 0; m_valid = 0; m_data = '0;
    end else if (init) begin
      gen(key, iv, 1152, 8192);
      m_ptr = 0; m_mode = 1; m_cnt = 144; m_valid = 0;
    end else if (m_mode == 1) begin
      m_cnt--;
      if (m_cnt == 0) m_mode = 2;
    end else if (m_mode == 2) begin
      if (in_valid && (!m_valid || out_ready)) begin
        m_data = in_data ^ ksw(m_ptr);
        m_ptr += 8;
        m_valid = 1;
      end else if (out_ready) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("busy", busy, m_mode == 1);
      chk("keyed", keyed, m_mode == 2);
      chk("in_ready", in_ready, m_mode == 2 && (!m_valid || out_ready));
      chk("out_valid", out_valid, m_valid);
      if (m_valid) chk("out_data", out_data, m_data);
    end
    if (v1 && a1 < 512) begin
      chk("w1_keystream", d1, ks0[a1]);
      a1++;
    end
    if (v64 && a64 < 8) begin
      chk("w64_keystream", d64, ks0w(a64));
      a64++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_init(input logic [79:0] k, input logic [79:0] v);
    @(posedge clk);
    #2;
    init = 1; key = k; iv = v;
    @(posedge clk);
    #2;
    init = 0; aux_en = 0;
  endtask

  task automatic wait_keyed();
    int n = 0, i = 0;
    while (!keyed && i < 3000) begin
      @(negedge clk);
      if (busy) n++;
      i++;
    end
    chk("busy_cycles", n, 144);
    chk("keyed_after_warmup", keyed, 1);
  endtask

  task automatic rand_traffic(input int n);
    repeat (n) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_data = 8'($urandom);
      cyc(1);
    end
  endtask

  function automatic logic [79:0] rnd80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    int hs;
    logic [7:0] held;
    gen(80'h0, 80'h0, 1152, 512);
    for (int i = 0; i < 512; i++) ks0[i] = ks[i];
    gen(80'h0, 80'h0, 0, 4);
    chk("model_pin_raw_z", {ks[3], ks[2], ks[1], ks[0]}, 4'h7);
    #1;
    rst = 0; aux_rst = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_keyed", keyed, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    cyc(2);
    rst = 1; aux_rst = 1;
    cyc(3);
    do_init(80'h0, 80'h0);
    wait_keyed();
    in_valid = 1; out_ready = 1; in_data = 0;
    cyc(16);
    rand_traffic(300);
    in_valid = 0; out_ready = 1;
    cyc(2);
    in_valid = 1; out_ready = 0; in_data = 8'hA5;
    hs = 0; held = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) hs++;
      if (i == 1) held = out_data;
      @(posedge clk);
      #2;
      in_data = 8'($urandom);
    end
    chk("stall_accepts", hs, 1);
    chk("stall_hold", out_data, held);
    out_ready = 1;
    hs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) hs++;
      @(posedge clk);
      #2;
      in_data = 8'($urandom);
    end
    chk("stream_accepts", hs, 200);
    out_ready = 0;
    cyc(1);
    out_ready = 1;
    do_init(80'h0, 80'h0);
    wait_keyed();
    in_data = 0;
    cyc(16);
    do_init(rnd80(), rnd80());
    wait_keyed();
    rand_traffic(150);
    do_init(rnd80(), rnd80());
    cyc(50);
    rst = 0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_keyed", keyed, 0);
    chk("async_out_valid", out_valid, 0);
    chk("async_out_data", out_data, 0);
    cyc(2);
    rst = 1;
    cyc(5);
    chk("idle_after_rst", busy, 0);
    in_valid = 0;
    for (int i = 0; i < 3000 && (a1 < 512 || a64 < 8); i++) @(negedge clk);
    chk("w1_bits_seen", a1, 512);
    chk("w64_words_seen", a64, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
